// File: rtl/fit_pkg.sv
// Shared constants and types for the fitter-array output collector.
package fit_pkg;

    localparam int NFIT   = 6;
    localparam int DATA_W = 64;
    localparam int CHI_W  = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    localparam int IDX_W = clog2(NFIT);

    typedef logic [IDX_W-1:0] fit_idx_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int ERR_OVERFLOW      = 0;
    localparam int ERR_OVERRUN       = 1;
    localparam int ERR_ILLEGAL_START = 2;

endpackage

// File: rtl/fitters_to_out_fsm_if.sv
// Fitter-side inputs and output-FIFO write port of the collector, bundled with master/slave views.
interface fitters_to_out_fsm_if;
    import fit_pkg::*;

    logic [NFIT-1:0]         start;
    logic [NFIT-1:0]         done;
    logic [NFIT*DATA_W-1:0]  fit_data;
    logic [NFIT*CHI_W-1:0]   fit_chi2;
    logic                    fifo_out_full;
    logic                    fifo_out_we;
    logic [DATA_W+CHI_W-1:0] fifo_out_din;

    modport master (
        output start, done, fit_data, fit_chi2, fifo_out_full,
        input  fifo_out_we, fifo_out_din
    );

    modport slave (
        input  start, done, fit_data, fit_chi2, fifo_out_full,
        output fifo_out_we, fifo_out_din
    );

endinterface

// File: rtl/fit_order_queue.sv
// Synchronous FIFO of fitter indices recording dispatch order; DEPTH must be a power of 2 (>= 2).
module fit_order_queue
    import fit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  fit_idx_t push_idx,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output logic     has_next,
    output fit_idx_t head,
    output fit_idx_t head_next
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fit_idx_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign has_next    = (count_q > CNT_W'(1));
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign rd_ptr_next = rd_ptr_q + 1'b1;
    assign head        = mem_q[rd_ptr_q];
    assign head_next   = mem_q[rd_ptr_next];

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the index storage is deliberately not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_idx;
    end

endmodule

// File: rtl/fitters_to_out_fsm.sv
// Collects fitter results and writes them to the output FIFO strictly in dispatch order.
// Optional chi2 rejection (adds n_rejected) when FITTERS_TO_OUT_CHI2_CUT_EN is defined.
module fitters_to_out_fsm
    import fit_pkg::*;
#(
    parameter int ORDER_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    fitters_to_out_fsm_if.slave bus,
    input  logic [CHI_W-1:0]    chi2_cut,
    output logic [31:0]         n_written,
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
    output logic [31:0]         n_rejected,
`endif
    output logic [2:0]          err
);
    state_e                  state_q, state_d;
    logic [NFIT-1:0]         valid_q, valid_d;
    logic [DATA_W-1:0]       slot_data_q [NFIT];
    logic [CHI_W-1:0]        slot_chi2_q [NFIT];
    logic                    we_q, we_d;
    logic [DATA_W+CHI_W-1:0] din_q, din_d;
    logic [31:0]             n_written_q, n_written_d;
    logic [2:0]              err_q, err_d;

    logic     start_onehot, start_multi;
    fit_idx_t start_idx;
    logic     q_full, q_empty, q_has_next, q_pop;
    fit_idx_t q_head, q_head_next;
    logic     head_ready, accept;

    assign start_onehot = (bus.start != '0) && ((bus.start & (bus.start - 1'b1)) == '0);
    assign start_multi  = (bus.start != '0) && !start_onehot;

    always_comb begin
        start_idx = '0;
        for (int i = 0; i < NFIT; i++)
            if (bus.start[i]) start_idx = fit_idx_t'(i);
    end

    fit_order_queue #(.DEPTH(ORDER_DEPTH)) u_order_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (start_onehot),
        .push_idx  (start_idx),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .has_next  (q_has_next),
        .head      (q_head),
        .head_next (q_head_next)
    );

`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
    logic [31:0] n_rejected_q, n_rejected_d;
    assign accept     = (slot_chi2_q[q_head] <= chi2_cut);
    assign n_rejected = n_rejected_q;
`else
    logic unused_chi2_cut;
    assign unused_chi2_cut = ^chi2_cut;
    assign accept          = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        we_d        = 1'b0;
        din_d       = din_q;
        n_written_d = n_written_q;
        err_d       = err_q;
        q_pop       = 1'b0;
        head_ready  = 1'b0;
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
        n_rejected_d = n_rejected_q;
`endif
        case (state_q)
            ST_INIT: state_d = ST_WAIT;
            ST_WAIT: begin
                head_ready = !q_empty && valid_q[q_head];
                if (head_ready && !bus.fifo_out_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                q_pop           = 1'b1;
                valid_d[q_head] = 1'b0;
                if (accept) begin
                    we_d        = 1'b1;
                    din_d       = {slot_chi2_q[q_head], slot_data_q[q_head]};
                    n_written_d = n_written_q + 32'd1;
                end
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
                else n_rejected_d = n_rejected_q + 32'd1;
`endif
                // Decide on the entry behind the one being popped; a repeat of the same fitter re-checks from WAIT.
                head_ready = q_has_next && valid_q[q_head_next] && (q_head_next != q_head);
                state_d    = (head_ready && !bus.fifo_out_full) ? ST_WRITE : ST_WAIT;
            end
            default: state_d = ST_INIT;
        endcase

        // A done on a slot being popped this cycle sees valid_d already cleared, so it is not an overrun.
        for (int i = 0; i < NFIT; i++) begin
            if (bus.done[i]) begin
                if (valid_d[i]) err_d[ERR_OVERRUN] = 1'b1;
                valid_d[i] = 1'b1;
            end
        end
        if (start_multi)           err_d[ERR_ILLEGAL_START] = 1'b1;
        if (start_onehot && q_full) err_d[ERR_OVERFLOW]     = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            valid_q     <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            n_written_q <= '0;
            err_q       <= '0;
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
            n_rejected_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            we_q        <= we_d;
            din_q       <= din_d;
            n_written_q <= n_written_d;
            err_q       <= err_d;
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
            n_rejected_q <= n_rejected_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NFIT; i++) begin
            if (bus.done[i]) begin
                slot_data_q[i] <= bus.fit_data[i*DATA_W +: DATA_W];
                slot_chi2_q[i] <= bus.fit_chi2[i*CHI_W +: CHI_W];
            end
        end
    end

    assign bus.fifo_out_we  = we_q;
    assign bus.fifo_out_din = din_q;
    assign n_written        = n_written_q;
    assign err              = err_q;

endmodule

// File: tb/tb_fitters_to_out_fsm.sv
// Self-checking bench for fitters_to_out_fsm: vector table, directed corner sequences, randomized ordering run.
module tb_fitters_to_out_fsm;
    import fit_pkg::*;

    typedef struct {
        int                          cyc;
        logic [DATA_W+CHI_W-1:0]     din;
    } wr_t;

    typedef struct {
        int                          idx;
        bit                          have;
        logic [DATA_W+CHI_W-1:0]     word;
    } exp_t;

    typedef struct {
        logic [NFIT-1:0] start;
        logic [2:0]      exp_err;
        int              exp_writes;
        int              exp_idx;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CHI_W-1:0]  chi2_cut = '1;
    logic [31:0]       n_written;
    logic [2:0]        err;
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
    logic [31:0]       n_rejected;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    wr_t  wr_log[$];

    bit   busy[NFIT];
    bit   need_done[NFIT];
    exp_t exp_q[$];
    int   seen;
    int   n_model;

    fitters_to_out_fsm_if bus();

    fitters_to_out_fsm #(.ORDER_DEPTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .chi2_cut  (chi2_cut),
        .n_written (n_written),
`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
        .n_rejected(n_rejected),
`endif
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Cycle label L = posedges seen so far; a write strobe seen at the negedge belongs to cycle L.
    always @(negedge clock) begin
        if (bus.fifo_out_we) wr_log.push_back('{cyc: cyc, din: bus.fifo_out_din});
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not end, limit 2000000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        bus.start         = '0;
        bus.done          = '0;
        bus.fit_data      = '0;
        bus.fit_chi2      = '0;
        bus.fifo_out_full = 1'b0;
        step(2);
        reset = 1'b0;
        wr_log.delete();
    endtask

    task automatic drive_done(input int i, input logic [DATA_W-1:0] d, input logic [CHI_W-1:0] c);
        bus.done[i]                      = 1'b1;
        bus.fit_data[i*DATA_W +: DATA_W] = d;
        bus.fit_chi2[i*CHI_W +: CHI_W]   = c;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int k = 0; k < budget && wr_log.size() < n; k++) step();
    endtask

    function automatic logic [DATA_W-1:0] data_of(input int i, input int tag);
        return {32'(tag) ^ 32'h5A00_0000, 32'(i) ^ 32'hC0DE_0000};
    endfunction

    function automatic logic [CHI_W-1:0] chi_of(input int i, input int tag);
        return CHI_W'(i * 7 + tag);
    endfunction

    function automatic logic [DATA_W+CHI_W-1:0] word_of(input int i, input int tag);
        return {chi_of(i, tag), data_of(i, tag)};
    endfunction

    // Model: results leave in start order, each carrying the last data delivered by its fitter.
    task automatic consume_writes();
        while (seen < wr_log.size()) begin
            if (exp_q.size() == 0 || !exp_q[0].have) begin
                checks++;
                errors++;
                $display("FAIL rand_unexpected_write: got 0x%0h at cycle %0d, expected no write", wr_log[seen].din, wr_log[seen].cyc);
            end else begin
                check($sformatf("rand_write%0d_fit%0d", n_model, exp_q[0].idx), wr_log[seen].din, exp_q[0].word);
                busy[exp_q[0].idx] = 1'b0;
                void'(exp_q.pop_front());
                n_model++;
            end
            seen++;
        end
    endtask

    task automatic deliver_done(input int j);
        logic [DATA_W-1:0] d;
        logic [CHI_W-1:0]  ch;
        d  = {$urandom, $urandom};
        ch = CHI_W'($urandom);
        drive_done(j, d, ch);
        need_done[j] = 1'b0;
        foreach (exp_q[k]) begin
            if (exp_q[k].idx == j) begin
                exp_q[k].have = 1'b1;
                exp_q[k].word = {ch, d};
            end
        end
    endtask

    task automatic run_random(input int ncycles);
        int i;
        int started;
        do_reset();
        seen    = 0;
        n_model = 0;
        exp_q.delete();
        for (int k = 0; k < NFIT; k++) begin
            busy[k]      = 1'b0;
            need_done[k] = 1'b0;
        end
        for (int c = 0; c < ncycles; c++) begin
            consume_writes();
            bus.start         = '0;
            bus.done          = '0;
            bus.fifo_out_full = ($urandom_range(0, 3) == 0);
            started           = -1;
            if ($urandom_range(0, 2) == 0) begin
                i = $urandom_range(0, NFIT - 1);
                if (!busy[i]) begin
                    busy[i]      = 1'b1;
                    need_done[i] = 1'b1;
                    bus.start[i] = 1'b1;
                    exp_q.push_back('{idx: i, have: 1'b0, word: '0});
                    started = i;
                end
            end
            for (int j = 0; j < NFIT; j++) begin
                if (need_done[j] && j != started && $urandom_range(0, 3) == 0) deliver_done(j);
            end
            step();
        end
        bus.start         = '0;
        bus.done          = '0;
        bus.fifo_out_full = 1'b0;
        for (int j = 0; j < NFIT; j++) if (need_done[j]) deliver_done(j);
        step();
        bus.done = '0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            consume_writes();
            step();
        end
        step(3);
        consume_writes();
        check("rand_drained", exp_q.size(), 0);
        check("rand_n_written", n_written, n_model);
        check("rand_err", err, 3'b000);
    endtask

    initial begin
        vec_t vecs[7];
        int   s;
        int   r;
        int   tag;

        vecs[0] = '{6'b000000, 3'b000, 0, 0};
        vecs[1] = '{6'b000001, 3'b000, 1, 0};
        vecs[2] = '{6'b000011, 3'b100, 0, 0};
        vecs[3] = '{6'b100000, 3'b000, 1, 5};
        vecs[4] = '{6'b111111, 3'b100, 0, 0};
        vecs[5] = '{6'b010100, 3'b100, 0, 0};
        vecs[6] = '{6'b001000, 3'b000, 1, 3};

        do_reset();
        check("reset_we", bus.fifo_out_we, 1'b0);
        check("reset_din", bus.fifo_out_din, '0);
        check("reset_n_written", n_written, 32'd0);
        check("reset_err", err, 3'b000);

        // One start pattern, then every fitter reports: only a one-hot start yields a write.
        foreach (vecs[v]) begin
            do_reset();
            tag       = 10 + v;
            bus.start = vecs[v].start;
            step();
            bus.start = '0;
            step();
            for (int i = 0; i < NFIT; i++) drive_done(i, data_of(i, tag), chi_of(i, tag));
            step();
            bus.done = '0;
            step(8);
            check($sformatf("tbl%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("tbl%0d_writes", v), wr_log.size(), vecs[v].exp_writes);
            if (vecs[v].exp_writes == 1 && wr_log.size() == 1)
                check($sformatf("tbl%0d_din", v), wr_log[0].din, word_of(vecs[v].exp_idx, tag));
        end

        // In order: fitter k starts in cycle s+k, done in s+12+k, written 3 cycles after its done.
        do_reset();
        s = cyc;
        for (int c = 0; c < 18; c++) begin
            bus.start = '0;
            bus.done  = '0;
            if (c < 6) bus.start[c] = 1'b1;
            if (c >= 12) drive_done(c - 12, data_of(c - 12, 1), chi_of(c - 12, 1));
            step();
        end
        bus.done = '0;
        wait_writes(6, 20);
        step(3);
        check("inorder_count", wr_log.size(), 6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++) begin
            check($sformatf("inorder_din%0d", k), wr_log[k].din, word_of(k, 1));
            check($sformatf("inorder_cyc%0d", k), wr_log[k].cyc, s + 15 + k);
        end
        check("inorder_n_written", n_written, 32'd6);

        // Out of order: dones 2,1,0; nothing leaves until fitter 0, then three back-to-back writes.
        do_reset();
        s = cyc;
        for (int c = 0; c < 16; c++) begin
            bus.start = '0;
            bus.done  = '0;
            if (c < 3) bus.start[c] = 1'b1;
            if (c == 5)  drive_done(2, data_of(2, 2), chi_of(2, 2));
            if (c == 10) drive_done(1, data_of(1, 2), chi_of(1, 2));
            if (c == 15) drive_done(0, data_of(0, 2), chi_of(0, 2));
            step();
        end
        bus.done = '0;
        wait_writes(3, 20);
        step(3);
        check("ooo_count", wr_log.size(), 3);
        for (int k = 0; k < 3 && k < wr_log.size(); k++) begin
            check($sformatf("ooo_din%0d", k), wr_log[k].din, word_of(k, 2));
            check($sformatf("ooo_cyc%0d", k), wr_log[k].cyc, s + 18 + k);
        end

        // Backpressure: four results wait behind full, then stream out in order once it drops.
        do_reset();
        bus.fifo_out_full = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.start = '0;
            bus.done  = '0;
            if (c < 4) bus.start[c] = 1'b1;
            if (c >= 5 && c < 9) drive_done(c - 5, data_of(c - 5, 3), chi_of(c - 5, 3));
            step();
        end
        bus.done = '0;
        check("bp_held", wr_log.size(), 0);
        r = cyc;
        bus.fifo_out_full = 1'b0;
        wait_writes(4, 20);
        step(3);
        check("bp_count", wr_log.size(), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
            check($sformatf("bp_din%0d", k), wr_log[k].din, word_of(k, 3));
            check($sformatf("bp_cyc%0d", k), wr_log[k].cyc, r + 2 + k);
        end
        check("bp_err", err, 3'b000);

        // Overrun: second done on fitter 3 before its pop replaces the first result.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            bus.start = '0;
            bus.done  = '0;
            if (c == 0) bus.start[3] = 1'b1;
            if (c == 2) drive_done(3, data_of(3, 4), chi_of(3, 4));
            if (c == 3) drive_done(3, data_of(3, 5), chi_of(3, 5));
            step();
        end
        bus.done = '0;
        wait_writes(1, 10);
        step(3);
        check("overrun_err", err, 3'b010);
        check("overrun_count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("overrun_din", wr_log[0].din, word_of(3, 5));

        // Done arriving in the very cycle its slot is popped: kept for the second dispatch, no error.
        do_reset();
        s = cyc;
        for (int c = 0; c < 6; c++) begin
            bus.start = '0;
            bus.done  = '0;
            if (c < 2) bus.start[4] = 1'b1;
            if (c == 3) drive_done(4, data_of(4, 6), chi_of(4, 6));
            if (c == 5) drive_done(4, data_of(4, 7), chi_of(4, 7));
            step();
        end
        bus.done = '0;
        wait_writes(2, 10);
        step(3);
        check("popdone_count", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            check("popdone_din0", wr_log[0].din, word_of(4, 6));
            check("popdone_cyc0", wr_log[0].cyc, s + 6);
            check("popdone_din1", wr_log[1].din, word_of(4, 7));
            check("popdone_cyc1", wr_log[1].cyc, s + 8);
        end
        check("popdone_err", err, 3'b000);

        // Overflow: 16 starts fill the queue exactly, the 17th is dropped.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.start = '0;
            bus.start[c % NFIT] = 1'b1;
            step();
        end
        bus.start = '0;
        check("ovf_sixteen_ok", err, 3'b000);
        bus.start[0] = 1'b1;
        step();
        bus.start = '0;
        check("ovf_err", err, 3'b001);

        // Reset mid-run discards queued dispatches.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bus.start = '0;
            bus.start[c] = 1'b1;
            step();
        end
        bus.start = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        wr_log.delete();
        for (int c = 0; c < 3; c++) begin
            bus.done = '0;
            drive_done(c, data_of(c, 8), chi_of(c, 8));
            step();
        end
        bus.done = '0;
        step(10);
        check("rst_mid_writes", wr_log.size(), 0);
        check("rst_mid_n_written", n_written, 32'd0);
        check("rst_mid_err", err, 3'b000);

`ifdef FITTERS_TO_OUT_CHI2_CUT_EN
        // chi2 cut at 100: 50 and 100 pass, 101 is dropped.
        do_reset();
        chi2_cut = CHI_W'(100);
        for (int c = 0; c < 7; c++) begin
            bus.start = '0;
            bus.done  = '0;
            if (c < 3) bus.start[c] = 1'b1;
            if (c == 4) drive_done(0, data_of(0, 9), CHI_W'(50));
            if (c == 5) drive_done(1, data_of(1, 9), CHI_W'(100));
            if (c == 6) drive_done(2, data_of(2, 9), CHI_W'(101));
            step();
        end
        bus.done = '0;
        step(12);
        check("cut_count", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            check("cut_din0", wr_log[0].din, {CHI_W'(50), data_of(0, 9)});
            check("cut_din1", wr_log[1].din, {CHI_W'(100), data_of(1, 9)});
        end
        check("cut_n_written", n_written, 32'd2);
        check("cut_n_rejected", n_rejected, 32'd1);
        chi2_cut = '1;
`endif

        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fitters_to_out_fsm.md
Name: fitters_to_out_fsm

Overview:
- Collector at the output end of the fitter array; mirrors the round-robin dispatcher that feeds combinations to the six fitters.
- Records the order in which fitters were started and latches each fitter's result on its done pulse.
- Writes results into the output FIFO strictly in dispatch order, so track order is preserved.
- Optionally drops results whose chi2 exceeds a programmable cut.

Parameters:
NFIT, 6, number of fitters (start/done width)
DATA_W, 64, fit result word width per fitter
CHI_W, 16, chi2 width per fitter
ORDER_DEPTH, 16, depth of dispatch-order queue (power of 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  NFIT  one-hot dispatch pulses, same signals that launch each fitter
done  in  NFIT  per-fitter result-ready pulse, one cycle
fit_data  in  NFIT*DATA_W  packed results; fitter i at bits [i*DATA_W +: DATA_W], valid in done cycle
fit_chi2  in  NFIT*CHI_W  packed chi2, same packing and timing
chi2_cut  in  CHI_W  acceptance threshold, quasi-static
fifo_out_full  in  1  output FIFO cannot accept a write
fifo_out_we  out  1  output FIFO write strobe
fifo_out_din  out  DATA_W+CHI_W  {chi2, data} of written result
n_written  out  32  results written since reset
err  out  3  sticky errors: [0] order-queue overflow, [1] result overrun, [2] illegal start (more than one bit set)

Behaviour:
- Reset (synchronous, active-high): state INIT; order queue empty; all slot-valid flags 0; fifo_out_we=0, fifo_out_din=0, n_written=0, err=0.
- Reset mid-operation discards queued order entries and latched results; nothing is written to the FIFO afterwards for pre-reset starts.
- Order queue:
  - On a one-hot start, push the encoded fitter index (0..NFIT-1).
  - start=0: no push.
  - Multiple bits set: no push, set err[2].
  - Push while queue full: entry dropped, set err[0].
- Slots:
  - done[i] latches fit_data/fit_chi2 of fitter i into slot i and sets valid[i] on the next edge.
  - done[i] while valid[i]=1 and slot i is not being popped that cycle: overwrite, set err[1].
  - done[i] in the same cycle slot i is popped: new data captured, valid[i] stays 1, no error.
- States:
  - INIT: one cycle, then WAIT.
  - WAIT: if queue non-empty, valid[head]=1 and ~fifo_out_full, go to WRITE; otherwise stay.
  - WRITE: register fifo_out_din from slot[head], pulse fifo_out_we, pop queue, clear valid[head], increment n_written. Next-state condition is the same as in WAIT, so back-to-back writes are allowed at one per cycle.
  - Any illegal state encoding goes to INIT.
- Latency: done at edge t sets valid at t. If that slot is the head and the FIFO is not full, fifo_out_we is high in the cycle after edge t+2, i.e. 2 cycles from done to write.
- Ordering: a later-dispatched fitter that finishes first is held until every earlier entry is written. No bypass.
- fifo_out_full is sampled only in WAIT/WRITE; the head stays pending while it is high.
- fifo_out_we is a single-cycle pulse per result; fifo_out_din holds its value between writes.
- n_written wraps modulo 2^32.

Optional Feature:
- Macro: FITTERS_TO_OUT_CHI2_CUT_EN.
- Defined:
  - In WRITE, a result with chi2 > chi2_cut (unsigned compare) is popped and its slot cleared, but fifo_out_we stays 0 and n_written does not increment.
  - Adds output n_rejected [31:0], reset 0, incremented per dropped result.
  - chi2 == chi2_cut is accepted.
- Undefined: every result is written; no n_rejected port; chi2_cut is ignored.

Decomposition:
- Shared package fit_pkg holds:
  - NFIT, DATA_W, CHI_W
  - state encoding constants (INIT, WAIT, WRITE)
  - error-bit index constants
  - fitter-index width function clog2(NFIT)
- One natural sub-module: fit_order_queue, a synchronous FIFO of fitter indices with push, pop, full, empty and head outputs. It is reusable by the dispatcher side for debug.

Test Plan:
- In-order: start fitters 0..5 on consecutive cycles; done each fitter 12 cycles after its start -> six writes in cycles 14..19, data in index order 0..5, n_written=6.
- Out-of-order: start 0,1,2; done order 2,1,0 with 5 cycles between each -> no write until done[0]; writes 0,1,2 on three consecutive cycles two cycles after done[0].
- Backpressure: hold fifo_out_full=1 while 4 results are latched, release -> 4 back-to-back writes beginning the cycle after release, order preserved, err=0.
- Errors: start=6'b000011 -> err[2]=1 and queue unchanged. Two done[3] without an intervening pop -> err[1]=1 and the second data is written. 17 starts with no done (ORDER_DEPTH=16) -> err[0]=1.
- Reset mid-run: 3 entries queued, assert reset for 1 cycle, then done on those fitters -> no writes; n_written=0, err=0.
- With FITTERS_TO_OUT_CHI2_CUT_EN and chi2_cut=100: results with chi2 50, 100, 101 -> two writes (50, 100), n_rejected=1.
